// File: rtl/execute_unit_pipe.sv
// Pipelined execute stage: operand/forward muxes, 1-cycle ALU ops, WIDTH-step shift-add MUL.
// ALU latency 1, MUL latency WIDTH+1; in_ready drops while a MUL runs or an unconsumed result is held.
module execute_unit_pipe #(
  parameter int WIDTH  = 16,
  parameter int FLAG_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic              sel_a,
  input  logic              sel_b,
  input  logic              use_imm,
  input  logic [1:0]        fwd_a,
  input  logic [1:0]        fwd_b,
  input  logic              flag_src,
  input  logic [WIDTH-1:0]  data1_val,
  input  logic [WIDTH-1:0]  data2_val,
  input  logic [WIDTH-1:0]  imm_val,
  input  logic [WIDTH-1:0]  fwd_alu,
  input  logic [WIDTH-1:0]  fwd_mem,
  input  logic [FLAG_W-1:0] flags_in,
  input  logic [FLAG_W-1:0] mem_flags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  result,
  output logic [WIDTH-1:0]  result_hi,
  output logic [FLAG_W-1:0] flags_out,
  output logic              busy
);
  localparam int SH_W  = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam int MSB = WIDTH - 1;

  localparam logic [2:0] OP_PASSA = 3'd0;
  localparam logic [2:0] OP_ADD   = 3'd1;
  localparam logic [2:0] OP_SUB   = 3'd2;
  localparam logic [2:0] OP_AND   = 3'd3;
  localparam logic [2:0] OP_OR    = 3'd4;
  localparam logic [2:0] OP_NOTA  = 3'd5;
  localparam logic [2:0] OP_SHL   = 3'd6;
  localparam logic [2:0] OP_MUL   = 3'd7;

  typedef enum logic {IDLE, MUL_BUSY} state_t;

  state_t             r_state, w_state_nxt;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_result, r_result_hi;
  logic [FLAG_W-1:0]  r_flags;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_acc, r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic               r_flag_src;
  logic [FLAG_W-1:0]  r_mem_flags, r_flags_in;

  logic               w_accept, w_is_mul;
  logic [WIDTH-1:0]   w_a_sel, w_b_sel, w_a, w_b, w_alu;
  logic [WIDTH:0]     w_add, w_sub, w_shl;
  logic [FLAG_W-1:0]  w_flags, w_mul_flags;
  logic [2*WIDTH-1:0] w_prod;

  assign in_ready  = (r_state == IDLE) && (!r_out_valid || out_ready) && !flush;
  assign w_accept  = in_valid && in_ready;
  assign w_is_mul  = (op == OP_MUL);
  assign busy      = (r_state == MUL_BUSY);
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign result_hi = r_result_hi;
  assign flags_out = r_flags;

  assign w_a_sel = sel_a ? data1_val : data2_val;
  assign w_b_sel = use_imm ? imm_val : (sel_b ? data2_val : {{(WIDTH-1){1'b0}}, 1'b1});
  assign w_a = (fwd_a == 2'b01) ? fwd_alu : (fwd_a == 2'b10) ? fwd_mem : w_a_sel;
  assign w_b = (fwd_b == 2'b01) ? fwd_alu : (fwd_b == 2'b10) ? fwd_mem : w_b_sel;

  // Bit WIDTH of each wide result is the carry / no-borrow / last bit shifted out.
  assign w_add = {1'b0, w_a} + {1'b0, w_b};
  assign w_sub = {1'b0, w_a} + {1'b0, ~w_b} + {{WIDTH{1'b0}}, 1'b1};
  assign w_shl = {1'b0, w_a} << w_b[SH_W-1:0];

  always_comb begin
    w_alu   = w_a;
    w_flags = flags_in;
    case (op)
      OP_ADD: begin
        w_alu      = w_add[WIDTH-1:0];
        w_flags[2] = w_add[WIDTH];
        w_flags[3] = (w_a[MSB] == w_b[MSB]) && (w_add[MSB] != w_a[MSB]);
      end
      OP_SUB: begin
        w_alu      = w_sub[WIDTH-1:0];
        w_flags[2] = w_sub[WIDTH];
        w_flags[3] = (w_a[MSB] != w_b[MSB]) && (w_sub[MSB] != w_a[MSB]);
      end
      OP_AND:  w_alu = w_a & w_b;
      OP_OR:   w_alu = w_a | w_b;
      OP_NOTA: w_alu = ~w_a;
      OP_SHL: begin
        w_alu = w_shl[WIDTH-1:0];
        if (w_b[SH_W-1:0] != '0) w_flags[2] = w_shl[WIDTH];
      end
      default: w_alu = w_a;
    endcase
    w_flags[0] = (w_alu == '0);
    w_flags[1] = w_alu[MSB];
    if (flag_src) w_flags = mem_flags;
  end

  assign w_prod = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_comb begin
    w_mul_flags    = r_flags_in;
    w_mul_flags[0] = (w_prod == '0);
    w_mul_flags[1] = w_prod[MSB];
    w_mul_flags[2] = |w_prod[2*WIDTH-1:WIDTH];
    w_mul_flags[3] = 1'b0;
    if (r_flag_src) w_mul_flags = r_mem_flags;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:     if (w_accept && w_is_mul) w_state_nxt = MUL_BUSY;
        MUL_BUSY: if (r_cnt == CNT_ONE) w_state_nxt = IDLE;
        default:  w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_flags     <= '0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_flag_src  <= 1'b0;
      r_mem_flags <= '0;
      r_flags_in  <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_cnt       <= '0;
    end else begin
      if (out_ready) r_out_valid <= 1'b0;
      if (w_accept) begin
        if (w_is_mul) begin
          r_acc       <= '0;
          r_mcand     <= {{WIDTH{1'b0}}, w_a};
          r_mplier    <= w_b;
          r_cnt       <= CNT_INIT;
          r_flag_src  <= flag_src;
          r_mem_flags <= mem_flags;
          r_flags_in  <= flags_in;
        end else begin
          r_result    <= w_alu;
          r_result_hi <= '0;
          r_flags     <= w_flags;
          r_out_valid <= 1'b1;
        end
      end else if (r_state == MUL_BUSY) begin
        r_acc    <= w_prod;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt - CNT_ONE;
        if (r_cnt == CNT_ONE) begin
          r_result    <= w_prod[WIDTH-1:0];
          r_result_hi <= w_prod[2*WIDTH-1:WIDTH];
          r_flags     <= w_mul_flags;
          r_out_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_execute_unit_pipe.sv
// Scoreboard bench for execute_unit_pipe: directed scenarios then randomized traffic
// against an arithmetic reference model.
module tb_execute_unit_pipe;
  localparam int W  = 16;
  localparam int FW = 4;

  logic          clk = 1'b0;
  logic          rst_n, flush, in_valid, in_ready;
  logic [2:0]    op;
  logic          sel_a, sel_b, use_imm, flag_src;
  logic [1:0]    fwd_a, fwd_b;
  logic [W-1:0]  data1_val, data2_val, imm_val, fwd_alu, fwd_mem;
  logic [FW-1:0] flags_in, mem_flags;
  logic          out_valid, out_ready, busy;
  logic [W-1:0]  result, result_hi;
  logic [FW-1:0] flags_out;

  always #5 clk = ~clk;

  execute_unit_pipe #(.WIDTH(W), .FLAG_W(FW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .sel_a(sel_a), .sel_b(sel_b), .use_imm(use_imm), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .flag_src(flag_src), .data1_val(data1_val), .data2_val(data2_val), .imm_val(imm_val),
    .fwd_alu(fwd_alu), .fwd_mem(fwd_mem), .flags_in(flags_in), .mem_flags(mem_flags),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .result_hi(result_hi),
    .flags_out(flags_out), .busy(busy)
  );

  typedef struct packed {
    logic [W-1:0]  res;
    logic [W-1:0]  hi;
    logic [FW-1:0] fl;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [FW-1:0] fi, input logic [FW-1:0] mf, input logic fs);
    exp_t            e;
    int unsigned     ua, ub, sh;
    int              sa, sbv, ss;
    longint unsigned p;
    logic            c, v, z, n;
    ua = a; ub = b; sa = $signed(a); sbv = $signed(b);
    p = 0; e.hi = '0; c = fi[2]; v = fi[3];
    case (o)
      3'd1: begin
        e.res = W'(ua + ub); c = (ua + ub) > 32'hFFFF;
        ss = sa + sbv; v = (ss > 32767) || (ss < -32768);
      end
      3'd2: begin
        e.res = W'(ua - ub); c = (ua >= ub);
        ss = sa - sbv; v = (ss > 32767) || (ss < -32768);
      end
      3'd3: e.res = a & b;
      3'd4: e.res = a | b;
      3'd5: e.res = ~a;
      3'd6: begin
        sh = ub % W; e.res = W'(ua << sh);
        if (sh != 0) c = ((ua >> (W - sh)) & 1) != 0;
      end
      3'd7: begin
        p = longint'(ua) * longint'(ub);
        e.res = p[W-1:0]; e.hi = p[2*W-1:W]; c = (e.hi != 0); v = 1'b0;
      end
      default: e.res = a;
    endcase
    z = (o == 3'd7) ? (p == 0) : (e.res == 0);
    n = e.res[W-1];
    e.fl = fs ? mf : {v, c, n, z};
    return e;
  endfunction

  function automatic exp_t expect_now();
    logic [W-1:0] a, b;
    a = sel_a ? data1_val : data2_val;
    b = use_imm ? imm_val : (sel_b ? data2_val : W'(1));
    if (fwd_a == 2'b01) a = fwd_alu; else if (fwd_a == 2'b10) a = fwd_mem;
    if (fwd_b == 2'b01) b = fwd_alu; else if (fwd_b == 2'b10) b = fwd_mem;
    return model(op, a, b, flags_in, mem_flags, flag_src);
  endfunction

  // Expected-response producer: an accept seen mid-cycle takes effect at the next edge.
  always @(negedge clk) begin
    if (!rst_n || flush) sb.delete();
    else if (in_valid && in_ready) sb.push_back(expect_now());
  end
  always @(negedge rst_n) sb.delete();

  exp_t got, e_pop, hold_val;
  logic hold_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      got = {result, result_hi, flags_out};
      if (hold_prev) chk("hold_stable", {out_valid, got}, {1'b1, hold_val});
      if (flush) begin
        hold_prev = 1'b0;
      end else if (out_valid && out_ready) begin
        chk("sb_has_entry", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e_pop = sb.pop_front();
          chk("sb_result", got, e_pop);
        end
        hold_prev = 1'b0;
      end else if (out_valid) begin
        hold_prev = 1'b1;
        hold_val  = got;
      end else begin
        hold_prev = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 0; flush = 0; op = 0; sel_a = 1; sel_b = 1; use_imm = 0; fwd_a = 0; fwd_b = 0;
    flag_src = 0; data1_val = 0; data2_val = 0; imm_val = 0; fwd_alu = 0; fwd_mem = 0;
    flags_in = 0; mem_flags = 0; out_ready = 1;
  endtask

  task automatic set_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    op = o; sel_a = 1; data1_val = a; use_imm = 1; imm_val = b;
    fwd_a = 0; fwd_b = 0; flag_src = 0; in_valid = 1;
  endtask

  // Waits for the handshake to be possible, lets the edge take it, then drops in_valid.
  task automatic wait_accept(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(name, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  function automatic logic [W-1:0] rnd_val();
    logic [W-1:0] tbl [4];
    tbl[0] = 16'h0000; tbl[1] = 16'hFFFF; tbl[2] = 16'h8000; tbl[3] = 16'h7FFF;
    if ($urandom_range(0, 3) == 0) return tbl[$urandom_range(0, 3)];
    return W'($urandom);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int seen;
    idle();
    rst_n = 0;
    #12;
    chk("reset_outputs", {out_valid, busy, result, result_hi, flags_out}, 0);
    chk("reset_in_ready", in_ready, 1);
    @(negedge clk); #2 rst_n = 1;
    step();

    // ADD signed overflow
    set_op(3'd1, 16'h7FFF, 16'h0001);
    wait_accept("add_accept");
    @(negedge clk);
    chk("add_latency", out_valid, 1);
    chk("add_result", result, 16'h8000);
    chk("add_flags", flags_out, 4'hA);

    // SUB through both forwarding paths, then flag_src override
    step();
    op = 3'd2; sel_a = 0; data2_val = 16'h1234; use_imm = 0; sel_b = 1;
    fwd_a = 2'b01; fwd_alu = 16'h0005; fwd_b = 2'b10; fwd_mem = 16'h0005; flag_src = 0; in_valid = 1;
    wait_accept("sub_accept");
    @(negedge clk);
    chk("sub_result", result, 16'h0000);
    chk("sub_flags", flags_out, 4'h5);
    step();
    flag_src = 1; mem_flags = 4'hA; in_valid = 1;
    wait_accept("memflag_accept");
    mem_flags = 4'h3; flag_src = 0;
    @(negedge clk);
    chk("memflag_flags", flags_out, 4'hA);

    // MUL latency and busy window
    step();
    set_op(3'd7, 16'hFFFF, 16'h0002);
    wait_accept("mul_accept");
    for (int k = 1; k <= W + 1; k++) begin
      @(negedge clk);
      if (k <= W) begin
        chk("mul_busy", {busy, in_ready, out_valid}, 3'b100);
      end else begin
        chk("mul_done", {busy, out_valid}, 2'b01);
        chk("mul_result", {result_hi, result}, 32'h0001_FFFE);
        chk("mul_flags", flags_out, 4'h6);
      end
    end

    // Output hold under back-pressure
    step();
    out_ready = 0;
    set_op(3'd1, 16'd1, 16'd2);
    wait_accept("hold_accept");
    set_op(3'd1, 16'd10, 16'd20);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_value", {out_valid, result}, {1'b1, 16'd3});
      step();
    end
    out_ready = 1;
    @(negedge clk);
    chk("release_in_ready", in_ready, 1);
    step();
    in_valid = 0;
    @(negedge clk);
    chk("release_next", {out_valid, result}, {1'b1, 16'd30});

    // Flush a MUL when its counter reads 5
    step();
    set_op(3'd7, 16'h1234, 16'h0101);
    wait_accept("flush_mul_accept");
    repeat (11) step();
    flush = 1;
    step();
    flush = 0;
    @(negedge clk);
    chk("flush_state", {busy, out_valid, in_ready}, 3'b001);
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("flush_no_stale", seen, 0);

    // Asynchronous reset mid-MUL
    step();
    set_op(3'd7, 16'h00FF, 16'h0003);
    wait_accept("rst_mul_accept");
    repeat (5) step();
    @(negedge clk); #3 rst_n = 0;
    #1;
    chk("async_reset", {out_valid, busy, result, result_hi, flags_out}, 0);
    @(negedge clk); #2 rst_n = 1;
    step();
    set_op(3'd1, 16'd3, 16'd4);
    wait_accept("post_reset_accept");
    @(negedge clk);
    chk("post_reset_add", {out_valid, result}, {1'b1, 16'd7});

    // Randomized traffic
    for (int c = 0; c < 2500; c++) begin
      step();
      in_valid  = ($urandom_range(0, 2) != 0);
      op        = 3'($urandom_range(0, 7));
      sel_a     = 1'($urandom); sel_b = 1'($urandom); use_imm = 1'($urandom);
      fwd_a     = 2'($urandom); fwd_b = 2'($urandom); flag_src = ($urandom_range(0, 7) == 0);
      data1_val = rnd_val(); data2_val = rnd_val(); imm_val = rnd_val();
      fwd_alu   = rnd_val(); fwd_mem = rnd_val();
      flags_in  = 4'($urandom); mem_flags = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 59) == 0);
    end
    step();
    in_valid = 0; flush = 0; out_ready = 1;
    repeat (W + 8) step();
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/execute_unit_pipe.md
Name: execute_unit_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle execute stage.
- Per instruction: selects operands with register/immediate/forwarding muxes, executes single-cycle ALU ops or a multi-cycle iterative multiply, and registers result plus flags into an output stage.
- Uses a valid/ready handshake on both sides so hazard/stall logic can back-pressure it.
- Sits between decode/register-read and the memory stage.

Parameters:
- WIDTH, 16, datapath width in bits (>=4).
- FLAG_W, 4, flag vector width; bit0=Z, bit1=N, bit2=C, bit3=V, bits above 3 pass through from flags_in.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- flush  in  1  synchronous abort of in-flight op and output stage.
- in_valid  in  1  instruction presented.
- in_ready  out  1  unit can accept this cycle.
- op  in  3  000 PASSA, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 NOTA, 110 SHL, 111 MUL.
- sel_a  in  1  1: A=data1_val, 0: A=data2_val.
- sel_b  in  1  1: B=data2_val, 0: B=1.
- use_imm  in  1  1: B=imm_val (overrides sel_b).
- fwd_a, fwd_b  in  2 each  00 muxed operand, 01 fwd_alu, 10 fwd_mem, 11 muxed operand.
- flag_src  in  1  1: output flags = mem_flags.
- data1_val, data2_val, imm_val, fwd_alu, fwd_mem  in  WIDTH each  operand sources.
- flags_in, mem_flags  in  FLAG_W each  current / memory-stage flags.
- out_valid  out  1  result register holds a valid result.
- out_ready  in  1  downstream consumes result.
- result  out  WIDTH  result (MUL: low half).
- result_hi  out  WIDTH  MUL high half; 0 for other ops.
- flags_out  out  FLAG_W  registered flags.
- busy  out  1  multiply in progress.

Behaviour:
- Reset (rst_n=0, any time, including mid-MUL): state=IDLE; out_valid=0; busy=0; result=0; result_hi=0; flags_out=0; iteration counter=0. Takes effect immediately, not on the next clock edge.
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
- Accept when in_valid && in_ready. Operands, op, flag_src, flags_in and mem_flags are all captured at the accept edge; later changes to those inputs have no effect.
- Operand resolution: B mux = use_imm ? imm_val : (sel_b ? data2_val : 1). Then the fwd_* mux is applied per operand.
- States: IDLE, MUL_BUSY.
- IDLE + accept, non-MUL op: result and flags are written at the accept edge. out_valid=1 from the next cycle (latency 1). State stays IDLE.
- IDLE + accept, MUL: load multiplicand/multiplier, clear the accumulator, counter=WIDTH, go to MUL_BUSY, busy=1.
- MUL_BUSY: one shift-add step per cycle; counter decrements.
  - The edge where counter goes 1->0 writes {result_hi,result}, sets out_valid, and returns to IDLE.
  - If a prior result is still held when accept occurs, that stall is already prevented by in_ready.
  - Latency: out_valid is first high WIDTH+1 cycles after the accept cycle.
- Output hold: out_valid stays 1 and result/flags stay stable until out_ready=1 at a clock edge. Then out_valid clears, unless a new single-cycle op is accepted on the same edge, which replaces the result (back-to-back throughput 1/cycle).
- Arithmetic is modulo 2^WIDTH.
  - ADD: C = carry out; V = signed overflow.
  - SUB: computed as A + ~B + 1; C = 1 when no borrow (A>=B unsigned); V = signed overflow.
  - SHL: shift by B[log2(WIDTH)-1:0]; C = last bit shifted out (shift 0: C from flags_in).
  - AND/OR/NOTA/PASSA: C and V taken from captured flags_in.
  - MUL: unsigned. Z = full 2*WIDTH product==0; N = result[WIDTH-1]; C = (result_hi!=0); V = 0.
  - For all ops except MUL: Z = (result==0); N = result[WIDTH-1].
  - flag_src=1: flags_out = captured mem_flags regardless of op.
- flush=1 at an edge: state→IDLE, busy=0, out_valid=0; no accept that cycle; result/flags values don't care. flush has priority over out_ready and over MUL completion on the same edge.
- No combinational path from in_* to out_*; out_ready reaches only in_ready.

Test Plan:
- ADD, WIDTH=16, A=0x7FFF, B=imm 0x0001, flag_src=0 -> next cycle out_valid=1, result=0x8000, N=1, V=1, C=0, Z=0.
- SUB with fwd_a=01 fwd_alu=0x0005, fwd_b=10 fwd_mem=0x0005 -> result=0, Z=1, C=1; flag_src=1 with mem_flags=0xA -> flags_out=0xA.
- MUL 0xFFFF*0x0002 -> busy for 16 cycles, in_ready=0 throughout, out_valid first high cycle 17 after accept, result=0xFFFE, result_hi=0x0001, C=1.
- out_ready=0 for 3 cycles while single-cycle ops are presented -> result held, in_ready=0; out_ready=1 -> accept that edge, new result next cycle, no drop or duplicate.
- flush asserted at MUL counter=5 -> busy=0, out_valid=0 next cycle, in_ready=1; no stale result ever appears.
- rst_n low mid-MUL (asynchronous, between edges) -> all outputs 0 immediately; after release an ADD 3+4 yields 7 with latency 1.
